// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
// Turns a single core load/store request into one bus transaction.
// Loads are returned sign- or zero-extended and stores are lane-replicated.
// Illegal or misaligned requests complete in one cycle with err=1 and
// never touch the bus.
//
// Ports:
//   clk, rst        : clock and asynchronous active-high reset
//   start           : core request, sampled only while idle
//   mem_we          : 1 = store, 0 = load
//   data_mem_opr    : load funct3 (lb/lh/lw/lbu/lhu)
//   data_mem_opw    : store byte mask (sb/sh/sw)
//   addr, wdata     : byte address and low-aligned store data
//   rdata           : extended load result, held until the next good load
//   busy            : an op is in flight
//   done, err       : one-cycle completion pulse, err qualifies done
//   bus_req/we/addr/wstrb/wdata : registered bus request, held until ack
//   bus_ack, bus_rdata          : bus completion and read word
//
// Bus handshake: bus_req rises the cycle after an accepted start, and
// bus_we/addr/wstrb/wdata are stable for as long as bus_req is high. A
// one-cycle bus_ack while bus_req is high completes the transfer; bus_rdata
// is only looked at in that cycle.
//
// Build option: define DMC_TIMEOUT_EN to abort a request after TIMEOUT
// unacknowledged REQ cycles. Without it the request waits forever.

module data_mem_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_we,
  input  logic [2:0]  data_mem_opr,
  input  logic [3:0]  data_mem_opw,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  // Load type and byte offset are kept so the lane can be picked at ack time.
  logic [2:0]  opr_q, opr_d;
  logic [1:0]  off_q, off_d;

  logic        op_ok;
  logic [3:0]  strb_new;
  logic [31:0] wdata_new;
  logic [31:0] rd_shift;
  logic [31:0] load_val;

`ifdef DMC_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  // The timeout length has no effect when the abort logic is not built.
  logic unused_timeout;
  assign unused_timeout = ^(32'(TIMEOUT));
`endif

  // Legal and naturally aligned request?
  always_comb begin
    op_ok = 1'b0;
    if (mem_we) begin
      case (data_mem_opw)
        4'b0001: op_ok = 1'b1;
        4'b0011: op_ok = ~addr[0];
        4'b1111: op_ok = (addr[1:0] == 2'b00);
        default: op_ok = 1'b0;
      endcase
    end else begin
      case (data_mem_opr)
        3'b000, 3'b100: op_ok = 1'b1;
        3'b001, 3'b101: op_ok = ~addr[0];
        3'b010:         op_ok = (addr[1:0] == 2'b00);
        default:        op_ok = 1'b0;
      endcase
    end
  end

  // Store strobes and replicated data; loads drive zeros on both.
  always_comb begin
    strb_new  = 4'b0000;
    wdata_new = 32'h0;
    if (mem_we) begin
      strb_new = data_mem_opw << addr[1:0];
      case (data_mem_opw)
        4'b0001: wdata_new = {4{wdata[7:0]}};
        4'b0011: wdata_new = {2{wdata[15:0]}};
        default: wdata_new = wdata;
      endcase
    end
  end

  // Bring the addressed byte/half down to bit 0, then extend.
  assign rd_shift = bus_rdata >> {off_q, 3'b000};

  always_comb begin
    case (opr_q)
      3'b000:  load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_val = {24'h0, rd_shift[7:0]};
      3'b101:  load_val = {16'h0, rd_shift[15:0]};
      default: load_val = rd_shift;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_wdata_d = bus_wdata_q;
    opr_d       = opr_q;
    off_d       = off_q;
`ifdef DMC_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        err_d = 1'b0;
        if (start) begin
          if (op_ok) begin
            state_d     = S_REQ;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_we;
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_wstrb_d = strb_new;
            bus_wdata_d = wdata_new;
            opr_d       = data_mem_opr;
            off_d       = addr[1:0];
`ifdef DMC_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end else begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (bus_ack) begin
          state_d   = S_DONE;
          bus_req_d = 1'b0;
          err_d     = 1'b0;
          if (!bus_we_q) rdata_d = load_val;
        end else begin
`ifdef DMC_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_W'(TIMEOUT)) begin
            state_d   = S_DONE;
            bus_req_d = 1'b0;
            err_d     = 1'b1;
          end
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
      default: begin
        state_d   = S_IDLE;
        bus_req_d = 1'b0;
        err_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wstrb_q <= 4'b0000;
      bus_wdata_q <= 32'h0;
      opr_q       <= 3'b000;
      off_q       <= 2'b00;
`ifdef DMC_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_wdata_q <= bus_wdata_d;
      opr_q       <= opr_d;
      off_q       <= off_d;
`ifdef DMC_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign rdata     = rdata_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wstrb = bus_wstrb_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 Parameter: TIMEOUT, 255, max REQ cycles before abort (used only with DMC_TIMEOUT_EN).
REQ-003 Ports SHALL be, in order:
  clk  in  1  clock, all state on rising edge
  rst  in  1  asynchronous active-high reset
  start  in  1  core requests one memory op (sampled in IDLE only)
  mem_we  in  1  1 store, 0 load
  data_mem_opr  in  3  load funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
  data_mem_opw  in  4  store byte mask: 0001 sb, 0011 sh, 1111 sw
  addr  in  32  byte address
  wdata  in  32  store data, low-aligned
  rdata  out  32  extended load result
  busy  out  1  op in flight, core stalls
  done  out  1  one-cycle completion pulse
  err  out  1  completion with error, valid with done
  bus_req  out  1  bus request, held until ack
  bus_we  out  1  bus write
  bus_addr  out  32  word address {addr[31:2],2'b00}
  bus_wstrb  out  4  byte strobes
  bus_wdata  out  32  lane-replicated write data
  bus_ack  in  1  bus completion, one cycle
  bus_rdata  in  32  read word, valid with bus_ack

Function
REQ-004 FSM states SHALL be IDLE, REQ, DONE.
REQ-005 IDLE: start with a legal, aligned op -> REQ; start with an illegal or misaligned op -> DONE with err=1 and no bus activity; otherwise stay.
REQ-006 Illegal: load opr 011/110/111; store opw other than 0001/0011/1111.
REQ-007 Misaligned: halfword with addr[0]=1; word with addr[1:0]!=00.
REQ-008 bus_* outputs SHALL be registered on entry to REQ and held stable until ack; bus_req rises the cycle after start.
REQ-009 bus_wstrb SHALL be data_mem_opw << addr[1:0] for stores and 0000 for loads.
REQ-010 bus_wdata SHALL be {4{wdata[7:0]}} for sb, {2{wdata[15:0]}} for sh, wdata for sw, and 0 for loads.
REQ-011 REQ: bus_ack=1 -> DONE next cycle, bus_req deasserted that edge.
REQ-012 Loads SHALL select the byte/half at addr[1:0] from bus_rdata, sign-extend (lb/lh) or zero-extend (lbu/lhu), and register it into rdata on the ack edge.
REQ-013 rdata SHALL hold its value until the next successful load; stores and errors leave it unchanged.
REQ-014 DONE SHALL last exactly one cycle with done=1, then return to IDLE; err=1 only if the op failed.
REQ-015 busy=1 in REQ and DONE, 0 in IDLE.
REQ-016 Latency SHALL be at least 2 cycles start-to-done on success and exactly 1 cycle on error.
REQ-017 start outside IDLE, and bus_ack outside REQ, SHALL be ignored.

Reset
REQ-018 While rst=1, asynchronously: state=IDLE; rdata, bus_addr, bus_wdata=0; bus_wstrb=0000; busy, done, err, bus_req, bus_we=0; timeout counter=0.
REQ-019 Reset during REQ SHALL drop bus_req immediately and discard the op; no done pulse.

Configuration
REQ-020 With DMC_TIMEOUT_EN defined, a counter SHALL clear on REQ entry and increment each REQ cycle without ack; on reaching TIMEOUT the FSM SHALL go to DONE with err=1, bus_req dropped, rdata unchanged.
REQ-021 With DMC_TIMEOUT_EN defined, an ack in the same cycle the count reaches TIMEOUT SHALL win (success).
REQ-022 Without DMC_TIMEOUT_EN, REQ SHALL wait indefinitely, no counter SHALL exist, and TIMEOUT SHALL be unused.

Verification
REQ-023 lb, addr=0x1003, bus_rdata=0x80FFFFFF, ack 3 cycles after bus_req -> rdata=0xFFFFFF80, done 1 cycle after ack, err=0.
REQ-024 sh, addr=0x2002, wdata=0x1234ABCD -> bus_addr=0x2000, bus_wstrb=1100, bus_wdata=0xABCDABCD, bus_we=1.
REQ-025 lw, addr=0x3001 -> done=err=1 the next cycle, bus_req never asserted, rdata unchanged.
REQ-026 lhu, addr=0x4002, bus_rdata=0x8001FFFF, ack in first REQ cycle -> rdata=0x00008001, start-to-done=2 cycles.
REQ-027 rst pulse while bus_req=1 -> bus_req=0 immediately, no done, next start proceeds normally.
REQ-028 DMC_TIMEOUT_EN, TIMEOUT=4, no ack -> done=err=1 after 4 REQ cycles; repeat with ack on 4th cycle -> err=0.
